// File: rtl/gb_apu_frame_sequencer.sv
// APU frame sequencer: 512 Hz frame tick driving an 8-step sequencer that emits length, sweep and envelope strobes.
// Optional macro GB_APU_FS_DIV_SYNC_EN replaces the internal prescaler with falling edges of the DIV-register bit div_bit.
module gb_apu_frame_sequencer #(
  parameter int CLK_DIV    = 8192,
  parameter int PRESCALE_W = $clog2(CLK_DIV)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       apu_en,
`ifdef GB_APU_FS_DIV_SYNC_EN
  input  logic       div_bit,
`endif
  output logic       clk_length_ctr,
  output logic       clk_sweep,
  output logic       clk_vol_env,
  output logic [2:0] frame_step
);

  logic [2:0] step_q, step_d;
  logic       length_q, length_d;
  logic       sweep_q, sweep_d;
  logic       vol_env_q, vol_env_d;
  logic       tick;

`ifdef GB_APU_FS_DIV_SYNC_EN
  logic div_bit_q;

  // div_bit_q follows div_bit even while disabled so a re-enable never sees a stale edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_bit_q <= 1'b0;
    end else begin
      div_bit_q <= div_bit;
    end
  end

  assign tick = div_bit_q & ~div_bit;
`else
  logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;

  assign tick = (prescaler_q == PRESCALE_W'(CLK_DIV - 1));

  always_comb begin
    prescaler_d = prescaler_q + PRESCALE_W'(1);
    if (!apu_en || tick) begin
      prescaler_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
    end else begin
      prescaler_q <= prescaler_d;
    end
  end
`endif

  always_comb begin
    step_d    = step_q;
    length_d  = 1'b0;
    sweep_d   = 1'b0;
    vol_env_d = 1'b0;
    if (!apu_en) begin
      step_d = 3'd0;
    end else if (tick) begin
      step_d = step_q + 3'd1;
      unique case (step_q)
        3'd0, 3'd4: length_d = 1'b1;
        3'd2, 3'd6: begin
          length_d = 1'b1;
          sweep_d  = 1'b1;
        end
        3'd7:       vol_env_d = 1'b1;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q    <= 3'd0;
      length_q  <= 1'b0;
      sweep_q   <= 1'b0;
      vol_env_q <= 1'b0;
    end else begin
      step_q    <= step_d;
      length_q  <= length_d;
      sweep_q   <= sweep_d;
      vol_env_q <= vol_env_d;
    end
  end

  assign clk_length_ctr = length_q;
  assign clk_sweep      = sweep_q;
  assign clk_vol_env    = vol_env_q;
  assign frame_step     = step_q;

endmodule

// File: tb/tb_gb_apu_frame_sequencer.sv
// Self-checking bench for gb_apu_frame_sequencer (CLK_DIV=4): constant vector table, directed corner cases, randomized run vs. a reference model.
module tb_gb_apu_frame_sequencer;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       apu_en;
  logic       divBit;
  logic       clk_length_ctr;
  logic       clk_sweep;
  logic       clk_vol_env;
  logic [2:0] frame_step;

  int errors = 0;
  int checks = 0;

  // reference model state: enabled-edge count, ticks since enable, last div_bit sample
  int         enCount;
  int         tickCnt;
  logic       prevDiv;
  logic [5:0] expVec;

  always #5 clk = ~clk;

  gb_apu_frame_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .apu_en         (apu_en),
`ifdef GB_APU_FS_DIV_SYNC_EN
    .div_bit        (divBit),
`endif
    .clk_length_ctr (clk_length_ctr),
    .clk_sweep      (clk_sweep),
    .clk_vol_env    (clk_vol_env),
    .frame_step     (frame_step)
  );

  typedef struct {
    logic       en;
    logic [5:0] exp;
  } vec_t;

  function automatic logic [5:0] dutVec();
    return {clk_length_ctr, clk_sweep, clk_vol_env, frame_step};
  endfunction

  function automatic void resetModel();
    enCount = 0;
    tickCnt = 0;
    prevDiv = 1'b0;
    expVec  = '0;
  endfunction

  // one clock edge of the reference model; expVec = {length, sweep, vol_env, step}
  function automatic void modelEdge(input logic en, input logic dv);
    bit tick;
    int s;
`ifdef GB_APU_FS_DIV_SYNC_EN
    tick = en && prevDiv && !dv;
`else
    enCount = en ? enCount + 1 : 0;
    tick = en && (enCount % CLK_DIV == 0);
`endif
    prevDiv = dv;
    if (!en) begin
      tickCnt = 0;
      expVec  = '0;
    end else if (tick) begin
      s = tickCnt % 8;
      expVec[5] = (s % 2 == 0);
      expVec[4] = (s == 2 || s == 6);
      expVec[3] = (s == 7);
      tickCnt++;
      expVec[2:0] = 3'(tickCnt % 8);
    end else begin
      expVec[5:3] = 3'b000;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [5:0] exp);
    checks++;
    if (dutVec() !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got len/sweep/env/step=%b required %b at %0t", name, dutVec(), exp, $time);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic dv);
    apu_en = en;
    divBit = dv;
    @(posedge clk);
    modelEdge(en, dv);
    #1;
    checkOutput("model", expVec);
  endtask

  task automatic doReset();
    apu_en = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    resetModel();
  endtask

  initial begin
    vec_t tbl[17];
    int   nLen, nSweep, nEnv, nSteps;
    logic [2:0] prevStep, heldStep;
    bit   found;
    logic en, dv;

    tbl[0]  = '{1'b1, 6'b000_000};
    tbl[1]  = '{1'b1, 6'b000_000};
    tbl[2]  = '{1'b1, 6'b000_000};
    tbl[3]  = '{1'b1, 6'b100_001};
    tbl[4]  = '{1'b1, 6'b000_001};
    tbl[5]  = '{1'b1, 6'b000_001};
    tbl[6]  = '{1'b1, 6'b000_001};
    tbl[7]  = '{1'b1, 6'b000_010};
    tbl[8]  = '{1'b1, 6'b000_010};
    tbl[9]  = '{1'b1, 6'b000_010};
    tbl[10] = '{1'b1, 6'b000_010};
    tbl[11] = '{1'b1, 6'b110_011};
    tbl[12] = '{1'b0, 6'b000_000};
    tbl[13] = '{1'b1, 6'b000_000};
    tbl[14] = '{1'b1, 6'b000_000};
    tbl[15] = '{1'b1, 6'b000_000};
    tbl[16] = '{1'b1, 6'b100_001};

    apu_en = 1'b0;
    divBit = 1'b0;
    rst_n  = 1'b0;
    resetModel();
    #12;
    checkOutput("reset", 6'b000_000);
    @(posedge clk);
    #1 rst_n = 1'b1;

`ifndef GB_APU_FS_DIV_SYNC_EN
    for (int i = 0; i < 17; i++) begin
      apu_en = tbl[i].en;
      @(posedge clk);
      modelEdge(tbl[i].en, 1'b0);
      #1;
      checkOutput($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // 32 ticks: pulse counts, envelope only on the 7->0 step transition
    doReset();
    nLen = 0; nSweep = 0; nEnv = 0;
    prevStep = frame_step;
    for (int i = 0; i < 32 * CLK_DIV; i++) begin
      applyStimulus(1'b1, 1'b0);
      nLen   += int'(clk_length_ctr);
      nSweep += int'(clk_sweep);
      nEnv   += int'(clk_vol_env);
      if (clk_vol_env) checkInt("envStepWrap", {prevStep, frame_step} == 6'b111_000 ? 1 : 0, 1);
      prevStep = frame_step;
    end
    checkInt("lengthCount", nLen, 16);
    checkInt("sweepCount", nSweep, 8);
    checkInt("envCount", nEnv, 4);

    // disable during the tick cycle of step 6, then re-enable
    doReset();
    for (int i = 0; i < 7 * CLK_DIV - 1; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("dropOnTick", 6'b000_000);
    for (int i = 0; i < CLK_DIV - 1; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("reenableFirst", 6'b100_001);
`else
    // one step per div_bit falling edge, none while div_bit is held high
    doReset();
    nSteps = 0;
    prevStep = frame_step;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, ((i / 4) % 2) == 0);
      if (frame_step != prevStep) nSteps++;
      prevStep = frame_step;
    end
    checkInt("divSteps", nSteps, 8);
    heldStep = frame_step;
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1);
    checkInt("divHeldStep", int'(frame_step), int'(heldStep));
`endif

    // async reset while the envelope strobe is high
    doReset();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
`ifdef GB_APU_FS_DIV_SYNC_EN
      applyStimulus(1'b1, ((i / 4) % 2) == 0);
`else
      applyStimulus(1'b1, 1'b0);
`endif
      found = clk_vol_env;
    end
    checkInt("envSeen", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncReset", 6'b000_000);
    #2 rst_n = 1'b1;
    resetModel();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("holdAfterReset", 6'b000_000);

    // randomized enables (and div_bit) against the model
    doReset();
    dv = 1'b0;
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 3) == 0) dv = ~dv;
      applyStimulus(en, dv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
